// File: rtl/bus2_pkg.sv
// Bus2 definitions shared by the cache and the memory controller: the command
// encoding, the bus widths and the line geometry.
package bus2_pkg;

  localparam int ADDR2_BUS_SIZE       = 14;
  localparam int DATA2_BUS_SIZE       = 16;
  localparam int DATA2_BUS_SIZE_BYTES = DATA2_BUS_SIZE / 8;
  localparam int LINE_BYTES           = 16;
  localparam int BEATS                = LINE_BYTES / DATA2_BUS_SIZE_BYTES;
  localparam int BEAT_W               = $clog2(BEATS);

  typedef enum logic [1:0] {
    C2_NOP        = 2'd0,
    C2_RESPONSE   = 2'd1,
    C2_READ_LINE  = 2'd2,
    C2_WRITE_LINE = 2'd3
  } c2_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_WAIT,
    ST_SEND
  } mem_state_e;

endpackage

// File: rtl/mem_line_array.sv
// Line storage addressed by (line, beat); one write port, one registered read port.
// Contents persist across reset.
module mem_line_array
  import bus2_pkg::*;
#(
  parameter int LINES = 256
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(LINES)-1:0]   wr_line,
  input  logic [BEAT_W-1:0]          wr_beat,
  input  logic [DATA2_BUS_SIZE-1:0]  wr_data,
  input  logic [$clog2(LINES)-1:0]   rd_line,
  input  logic [BEAT_W-1:0]          rd_beat,
  output logic [DATA2_BUS_SIZE-1:0]  rd_data
);

  logic [DATA2_BUS_SIZE-1:0] mem_q [LINES*BEATS];
  logic [DATA2_BUS_SIZE-1:0] rd_data_q;

  // NOTE: the array has no reset so it maps onto RAM and keeps its contents
  // across RESET; non-blocking assignments keep read-before-write ordering.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[{wr_line, wr_beat}] <= wr_data;
    end
    rd_data_q <= mem_q[{rd_line, rd_beat}];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/mem_ctrl.sv
// Bus2 memory controller: accepts READ_LINE / WRITE_LINE from the cache and
// answers with RESPONSE cycles a fixed MEM_LATENCY after acceptance.
module mem_ctrl
  import bus2_pkg::*;
#(
  parameter int MEM_LINES   = 256,
  parameter int MEM_LATENCY = 16
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [1:0]                 C2_IN,
  input  logic [ADDR2_BUS_SIZE-1:0]  A2_IN,
  input  logic [DATA2_BUS_SIZE-1:0]  D2_IN,
  output logic [1:0]                 C2_OUT,
  output logic [DATA2_BUS_SIZE-1:0]  D2_OUT,
  output logic                       BUS2_OE
);

  localparam int                LINE_W    = $clog2(MEM_LINES);
  localparam int                CNT_W     = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(MEM_LATENCY - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  mem_state_e                state_q, state_d;
  logic                      is_write_q, is_write_d;
  logic [LINE_W-1:0]         line_q, line_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  c2_cmd_e                   c2_out_q, c2_out_d;
  logic [DATA2_BUS_SIZE-1:0] d2_out_q, d2_out_d;
  logic                      oe_q, oe_d;
  logic                      commit_q, commit_d;
  logic [LINE_W-1:0]         commit_line_q, commit_line_d;
  logic [BEAT_W-1:0]         commit_beat_q, commit_beat_d;

  logic [DATA2_BUS_SIZE-1:0] hold_q [BEATS];
  logic                      hold_we;
  logic [BEAT_W-1:0]         hold_idx;
  logic [BEAT_W-1:0]         rd_beat;
  logic [DATA2_BUS_SIZE-1:0] rd_data;
  c2_cmd_e                   c2_in;
  logic                      unused_addr;

  assign c2_in       = c2_cmd_e'(C2_IN);
  assign unused_addr = ^A2_IN;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    is_write_d    = is_write_q;
    line_d        = line_q;
    cnt_d         = cnt_q;
    beat_d        = beat_q;
    c2_out_d      = C2_NOP;
    d2_out_d      = '0;
    oe_d          = 1'b0;
    hold_we       = 1'b0;
    hold_idx      = beat_q;
    rd_beat       = '0;
    commit_d      = commit_q;
    commit_line_d = commit_line_q;
    commit_beat_d = commit_beat_q;

    // The commit engine drains the holding buffer into storage one beat per cycle.
    if (commit_q) begin
      commit_beat_d = commit_beat_q + 1'b1;
      if (commit_beat_q == LAST_BEAT) commit_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (c2_in == C2_READ_LINE || c2_in == C2_WRITE_LINE) begin
          is_write_d = (c2_in == C2_WRITE_LINE);
          line_d     = A2_IN[LINE_W-1:0];
          cnt_d      = CNT_LOAD;
          beat_d     = BEAT_W'(1);
          hold_we    = is_write_d;
          hold_idx   = '0;
          state_d    = is_write_d ? ST_RECV : ST_WAIT;
        end
      end
      ST_RECV: begin
        cnt_d   = cnt_q - 1'b1;
        hold_we = 1'b1;
        beat_d  = beat_q + 1'b1;
        if (beat_q == LAST_BEAT) begin
          state_d       = ST_WAIT;
          commit_d      = 1'b1;
          commit_line_d = line_q;
          commit_beat_d = '0;
        end
      end
      ST_WAIT: begin
        cnt_d   = cnt_q - 1'b1;
        // Storage reads are registered, so beat 0 is fetched one edge early.
        rd_beat = (cnt_q == '0) ? BEAT_W'(1) : '0;
        if (cnt_q == '0) begin
          state_d  = ST_SEND;
          cnt_d    = '0;
          beat_d   = '0;
          oe_d     = 1'b1;
          c2_out_d = C2_RESPONSE;
          d2_out_d = is_write_q ? '0 : rd_data;
        end
      end
      ST_SEND: begin
        rd_beat = beat_q + BEAT_W'(2);
        if (!is_write_q && beat_q != LAST_BEAT) begin
          beat_d   = beat_q + 1'b1;
          oe_d     = 1'b1;
          c2_out_d = C2_RESPONSE;
          d2_out_d = rd_data;
        end else begin
          state_d = ST_IDLE;
          beat_d  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= ST_IDLE;
      is_write_q    <= 1'b0;
      line_q        <= '0;
      cnt_q         <= '0;
      beat_q        <= '0;
      c2_out_q      <= C2_NOP;
      d2_out_q      <= '0;
      oe_q          <= 1'b0;
      commit_q      <= 1'b0;
      commit_line_q <= '0;
      commit_beat_q <= '0;
    end else begin
      state_q       <= state_d;
      is_write_q    <= is_write_d;
      line_q        <= line_d;
      cnt_q         <= cnt_d;
      beat_q        <= beat_d;
      c2_out_q      <= c2_out_d;
      d2_out_q      <= d2_out_d;
      oe_q          <= oe_d;
      commit_q      <= commit_d;
      commit_line_q <= commit_line_d;
      commit_beat_q <= commit_beat_d;
    end
  end

  // Write beats land here first; a reset before the last beat leaves storage untouched.
  always_ff @(posedge CLK) begin
    if (hold_we) hold_q[hold_idx] <= D2_IN;
  end

  mem_line_array #(
    .LINES(MEM_LINES)
  ) u_array (
    .clk     (CLK),
    .wr_en   (commit_q),
    .wr_line (commit_line_q),
    .wr_beat (commit_beat_q),
    .wr_data (hold_q[commit_beat_q]),
    .rd_line (line_q),
    .rd_beat (rd_beat),
    .rd_data (rd_data)
  );

  assign C2_OUT  = c2_out_q;
  assign D2_OUT  = d2_out_q;
  assign BUS2_OE = oe_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a scoreboard queue holds each expected response
// cycle (edge number and data); a negedge monitor pops and compares.
module tb_mem_ctrl;
  import bus2_pkg::*;

  localparam int LINES   = 256;
  localparam int LATENCY = 16;

  logic                      CLK = 1'b0;
  logic                      RESET;
  logic [1:0]                C2_IN;
  logic [ADDR2_BUS_SIZE-1:0] A2_IN;
  logic [DATA2_BUS_SIZE-1:0] D2_IN;
  logic [1:0]                C2_OUT;
  logic [DATA2_BUS_SIZE-1:0] D2_OUT;
  logic                      BUS2_OE;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model [LINES][BEATS];
  int          cyc    = 0;
  int          n_vec  = 0;
  int          n_err  = 0;

  mem_ctrl #(
    .MEM_LINES  (LINES),
    .MEM_LATENCY(LATENCY)
  ) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .C2_IN  (C2_IN),
    .A2_IN  (A2_IN),
    .D2_IN  (D2_IN),
    .C2_OUT (C2_OUT),
    .D2_OUT (D2_OUT),
    .BUS2_OE(BUS2_OE)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] beat_val(input logic [15:0] base, input int k);
    return base + 16'(k * 16'h0202);
  endfunction

  // Response monitor: every OE cycle must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (RESET === 1'b1) begin
      if (BUS2_OE === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 32'(BUS2_OE), 32'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("resp_cycle", 32'(cyc), 32'(e.cyc));
          check("resp_cmd", 32'(C2_OUT), 32'(C2_RESPONSE));
          check("resp_data", 32'(D2_OUT), 32'(e.data));
        end
      end else begin
        check("idle_cmd", 32'(C2_OUT), 32'(C2_NOP));
        check("idle_data", 32'(D2_OUT), 32'(0));
      end
    end
  end

  // Called at a negedge; the command is sampled at the next rising edge.
  task automatic do_read(input logic [13:0] addr);
    int t;
    C2_IN = C2_READ_LINE;
    A2_IN = addr;
    t     = cyc + 1;
    for (int k = 0; k < BEATS; k++) sb.push_back('{t + LATENCY + k, model[addr % LINES][k]});
    @(negedge CLK);
    C2_IN = C2_NOP;
  endtask

  task automatic do_write(input logic [13:0] addr, input logic [15:0] base, input bit live);
    int t;
    C2_IN = C2_WRITE_LINE;
    A2_IN = addr;
    D2_IN = beat_val(base, 0);
    t     = cyc + 1;
    for (int k = 1; k < BEATS; k++) begin
      @(negedge CLK);
      C2_IN = C2_NOP;
      D2_IN = beat_val(base, k);
    end
    @(negedge CLK);
    D2_IN = '0;
    if (live) begin
      sb.push_back('{t + LATENCY, 16'h0000});
      for (int k = 0; k < BEATS; k++) model[addr % LINES][k] = beat_val(base, k);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || BUS2_OE !== 1'b0) && n < 80) begin
      @(negedge CLK);
      n++;
    end
    check(tag, 32'(sb.size()), 32'(0));
    repeat (2) @(negedge CLK);
  endtask

  task automatic wait_oe(input logic level, input string tag);
    int n = 0;
    while (BUS2_OE !== level && n < 64) begin
      @(negedge CLK);
      n++;
    end
    check(tag, 32'(BUS2_OE), 32'(level));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_oe"}, 32'(BUS2_OE), 32'(0));
    check({tag, "_cmd"}, 32'(C2_OUT), 32'(C2_NOP));
    check({tag, "_data"}, 32'(D2_OUT), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    C2_IN = C2_NOP;
    A2_IN = '0;
    D2_IN = '0;
    #2 RESET = 1'b0;
    #1 check_reset_outputs("reset_init");
    repeat (3) @(negedge CLK);
    #2 RESET = 1'b1;

    // Write line 5 with the byte ramp, then read it back.
    @(negedge CLK);
    do_write(14'h005, 16'h0100, 1'b1);
    drain("drain_write5");
    do_read(14'h005);
    drain("drain_read5");

    // A write arriving three edges into a read must be ignored entirely.
    do_read(14'h005);
    repeat (2) @(negedge CLK);
    do_write(14'h005, 16'h5A5A, 1'b0);
    drain("drain_ignored");
    do_read(14'h005);
    drain("drain_read5_again");

    // Lines 0x105 and 0x005 alias with 256 lines.
    do_write(14'h105, 16'hC030, 1'b1);
    drain("drain_write105");
    do_read(14'h005);
    drain("drain_alias");

    // Back-to-back: new read on the first IDLE edge after the last beat.
    do_read(14'h005);
    wait_oe(1'b1, "b2b_oe_rise");
    wait_oe(1'b0, "b2b_oe_fall");
    do_read(14'h005);
    drain("drain_b2b");

    // Reset in the middle of a write to line 7 must not disturb its old contents.
    do_write(14'h007, 16'h1357, 1'b1);
    drain("drain_write7");
    C2_IN = C2_WRITE_LINE;
    A2_IN = 14'h007;
    D2_IN = beat_val(16'hE0F0, 0);
    for (int k = 1; k < 4; k++) begin
      @(negedge CLK);
      C2_IN = C2_NOP;
      D2_IN = beat_val(16'hE0F0, k);
    end
    @(negedge CLK);
    #2 RESET = 1'b0;
    D2_IN = '0;
    #1 check_reset_outputs("reset_mid_write");
    repeat (2) @(negedge CLK);
    #2 RESET = 1'b1;
    do_read(14'h007);
    drain("drain_read7");

    // Reset while a read response is on the bus clears the outputs at once.
    do_read(14'h007);
    wait_oe(1'b1, "send_oe_rise");
    @(negedge CLK);
    #2 RESET = 1'b0;
    #1 check_reset_outputs("reset_mid_send");
    sb.delete();
    repeat (2) @(negedge CLK);
    #2 RESET = 1'b1;
    do_read(14'h005);
    drain("drain_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter MEM_LINES, 256: number of cache-line-sized entries stored; power of two.
REQ-002 Parameter MEM_LATENCY, 16: cycles from command acceptance to first response cycle; SHALL be >= BEATS+1.
REQ-003 Parameter LINE_BYTES, 16; DATA2_BUS_SIZE, 16; ADDR2_BUS_SIZE, 14; BEATS = LINE_BYTES/(DATA2_BUS_SIZE/8) = 8.
REQ-004 CLK  in  1  single clock; all state changes on rising edge.
REQ-005 RESET  in  1  reset, asynchronous and active-low.
REQ-006 C2_IN  in  2  command from cache: NOP=0, RESPONSE=1, READ_LINE=2, WRITE_LINE=3.
REQ-007 A2_IN  in  ADDR2_BUS_SIZE  line address (tag,set), sampled with command.
REQ-008 D2_IN  in  DATA2_BUS_SIZE  write-line data beats from cache.
REQ-009 C2_OUT  out  2  command driven by memory.
REQ-010 D2_OUT  out  DATA2_BUS_SIZE  read-line data beats.
REQ-011 BUS2_OE  out  1  high while memory owns bus2; C2_OUT/D2_OUT meaningful only then.

Function
REQ-012 States: IDLE, RECV, WAIT, SEND; registered outputs only.
REQ-013 IDLE: at edge T with C2_IN in {READ_LINE, WRITE_LINE}: latch command, line index = A2_IN mod MEM_LINES, load latency counter; other codes ignored.
REQ-014 WRITE_LINE: beat k (k=0..BEATS-1) sampled at edge T+k; bytes 2k = D2_IN[7:0], 2k+1 = D2_IN[15:8] (little-endian); state RECV during beats 1..BEATS-1, then WAIT.
REQ-015 Written line committed to storage after last beat, before response; line fully replaced.
REQ-016 READ_LINE: IDLE -> WAIT directly; C2_IN/D2_IN ignored until response done.
REQ-017 WAIT -> SEND such that first cycle with BUS2_OE=1 and C2_OUT=RESPONSE begins at edge T+MEM_LATENCY.
REQ-018 Read response: BEATS consecutive cycles, C2_OUT=RESPONSE each, D2_OUT beat k = {byte 2k+1, byte 2k}.
REQ-019 Write response: exactly one cycle C2_OUT=RESPONSE, D2_OUT=0.
REQ-020 After final response cycle: BUS2_OE=0, C2_OUT=NOP, D2_OUT=0, IDLE; new command acceptable at the following edge.
REQ-021 Commands arriving while not IDLE SHALL be ignored (no queueing, no state change).
REQ-022 BUS2_OE=0 at all times outside SEND; never asserted in the same cycle as command acceptance.
REQ-023 Address wrap: A2_IN bits above log2(MEM_LINES) ignored; lines i and i+MEM_LINES alias.
REQ-024 Latency counter width = clog2(MEM_LATENCY+1); no overflow permitted.

Reset
REQ-025 RESET low: immediately C2_OUT=NOP, D2_OUT=0, BUS2_OE=0, state IDLE, counters 0.
REQ-026 Reset mid-operation aborts the transaction; partially received write beats SHALL NOT be committed.
REQ-027 Storage contents not cleared by reset; first command accepted at first rising edge after RESET high.

Structure
REQ-028 Shared package bus2_pkg: C2 command enum, ADDR2/DATA2 widths, LINE_BYTES, BEATS, DATA2_BUS_SIZE_BYTES; shared with the cache.
REQ-029 One sub-module mem_line_array: synchronous beat-addressed storage (line index, beat index, write enable, 16-bit data), no reset.
REQ-030 mem_ctrl holds FSM, counters, beat index, write-beat holding buffer.

Verification
REQ-031 WRITE_LINE addr 0x005, beats 0x0100,0x0302..0x0F0E -> single RESPONSE at T+16, OE high 1 cycle.
REQ-032 Then READ_LINE addr 0x005 -> RESPONSE cycles T+16..T+23, D2_OUT 0x0100,0x0302..0x0F0E in order.
REQ-033 READ_LINE at T, WRITE_LINE at T+3 -> second ignored; only one read response.
REQ-034 WRITE_LINE to 0x105 (MEM_LINES=256) then READ 0x005 -> returns 0x105 data (wrap).
REQ-035 RESET low at T+4 of WRITE_LINE to line 7 -> outputs reset immediately; subsequent read of line 7 returns prior contents.
REQ-036 Back-to-back: READ_LINE at edge after last response beat -> accepted, response at +16.
